// File: rtl/kiwi_abend_monitor.sv
// kiwi_abend_monitor: sits downstream of the Kiwi DUT, captures the first
// terminal abend syndrome, counts clocks spent running, and after a fixed
// drain interval raises a sticky finish request.
// Optional feature macro: KIWI_ABEND_WATCHDOG_EN (cycle-count watchdog).
module kiwi_abend_monitor #(
  parameter int unsigned CYCLE_W          = 32,
  parameter int unsigned TIMEOUT_CYCLES   = 500000,
  parameter int unsigned DRAIN_CYCLES     = 25,
  parameter logic [7:0]  TIMEOUT_SYNDROME = 8'hFD
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         ksubsAbendSyndrome,
  output logic               finished,
  output logic [7:0]         final_syndrome,
  output logic [CYCLE_W-1:0] cycle_count,
  output logic               timed_out,
  output logic               heartbeat_seen,
  output logic               finish_req
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [7:0] SYN_IDLE = 8'h00;
  localparam logic [7:0] SYN_BEAT = 8'h80;

  localparam int unsigned DW = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
  localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYCLES);

  // Watchdog limit must be representable in the cycle counter.
  if (CYCLE_W < 32 && 64'(TIMEOUT_CYCLES) >= (64'd1 << CYCLE_W)) begin : g_bad_timeout
    $error("kiwi_abend_monitor: TIMEOUT_CYCLES must be < 2**CYCLE_W");
  end
  if (TIMEOUT_CYCLES == 0) begin : g_zero_timeout
    $error("kiwi_abend_monitor: TIMEOUT_CYCLES must be at least 1");
  end

`ifdef KIWI_ABEND_WATCHDOG_EN
  localparam logic [CYCLE_W-1:0] WD_LAST  = CYCLE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CYCLE_W-1:0] WD_LIMIT = CYCLE_W'(TIMEOUT_CYCLES);
`endif

  logic [1:0]         state_q,    state_d;
  logic               finished_q, finished_d;
  logic [7:0]         syn_q,      syn_d;
  logic [CYCLE_W-1:0] cycle_q,    cycle_d;
  logic               hb_q,       hb_d;
  logic               freq_q,     freq_d;
  logic [DW-1:0]      drain_q,    drain_d;
`ifdef KIWI_ABEND_WATCHDOG_EN
  logic               to_q,       to_d;
`endif

  logic terminal;
  assign terminal = (ksubsAbendSyndrome != SYN_IDLE) && (ksubsAbendSyndrome != SYN_BEAT);

  // Next-state logic: run/count, capture on terminal or watchdog, then drain.
  always_comb begin
    state_d    = state_q;
    finished_d = finished_q;
    syn_d      = syn_q;
    cycle_d    = cycle_q;
    hb_d       = hb_q;
    freq_d     = freq_q;
    drain_d    = drain_q;
`ifdef KIWI_ABEND_WATCHDOG_EN
    to_d       = to_q;
`endif
    case (state_q)
      ST_RUN: begin
        if (cycle_q != '1) cycle_d = cycle_q + CYCLE_W'(1);
        if (ksubsAbendSyndrome == SYN_BEAT) hb_d = 1'b1;
        // Terminal input is tested first so it wins over a coincident expiry.
        if (terminal) begin
          state_d    = ST_DRAIN;
          finished_d = 1'b1;
          syn_d      = ksubsAbendSyndrome;
          drain_d    = DRAIN_INIT;
`ifdef KIWI_ABEND_WATCHDOG_EN
          to_d       = 1'b0;
        end else if (cycle_q == WD_LAST) begin
          state_d    = ST_DRAIN;
          finished_d = 1'b1;
          syn_d      = TIMEOUT_SYNDROME;
          cycle_d    = WD_LIMIT;
          drain_d    = DRAIN_INIT;
          to_d       = 1'b1;
`endif
        end
      end
      ST_DRAIN: begin
        if (drain_q == '0) begin
          state_d = ST_DONE;
          freq_d  = 1'b1;
        end else begin
          drain_d = drain_q - DW'(1);
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  // State register with synchronous, highest-priority reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_RUN;
      finished_q <= 1'b0;
      syn_q      <= '0;
      cycle_q    <= '0;
      hb_q       <= 1'b0;
      freq_q     <= 1'b0;
      drain_q    <= '0;
`ifdef KIWI_ABEND_WATCHDOG_EN
      to_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      finished_q <= finished_d;
      syn_q      <= syn_d;
      cycle_q    <= cycle_d;
      hb_q       <= hb_d;
      freq_q     <= freq_d;
      drain_q    <= drain_d;
`ifdef KIWI_ABEND_WATCHDOG_EN
      to_q       <= to_d;
`endif
    end
  end

  assign finished       = finished_q;
  assign final_syndrome = syn_q;
  assign cycle_count    = cycle_q;
  assign heartbeat_seen = hb_q;
  assign finish_req     = freq_q;
`ifdef KIWI_ABEND_WATCHDOG_EN
  assign timed_out      = to_q;
`else
  assign timed_out      = 1'b0;
`endif

endmodule

// File: tb/tb_kiwi_abend_monitor.sv
// Directed self-checking bench for kiwi_abend_monitor. Two instances:
// u_dut (TIMEOUT 20, DRAIN 25) and u_dut2 (4-bit counter, TIMEOUT 10, DRAIN 0).
module tb_kiwi_abend_monitor;

  logic        clk;
  logic        reset;
  logic [7:0]  syn;
  logic [7:0]  syn2;

  logic        finished,  finished2;
  logic [7:0]  fsyn,      fsyn2;
  logic [31:0] ccount;
  logic [3:0]  ccount2;
  logic        tout,      tout2;
  logic        hb,        hb2;
  logic        freq,      freq2;

  int n_checks = 0;
  int n_errors = 0;

  kiwi_abend_monitor #(
    .CYCLE_W(32), .TIMEOUT_CYCLES(20), .DRAIN_CYCLES(25), .TIMEOUT_SYNDROME(8'hFD)
  ) u_dut (
    .clk(clk), .reset(reset), .ksubsAbendSyndrome(syn),
    .finished(finished), .final_syndrome(fsyn), .cycle_count(ccount),
    .timed_out(tout), .heartbeat_seen(hb), .finish_req(freq)
  );

  kiwi_abend_monitor #(
    .CYCLE_W(4), .TIMEOUT_CYCLES(10), .DRAIN_CYCLES(0), .TIMEOUT_SYNDROME(8'hFD)
  ) u_dut2 (
    .clk(clk), .reset(reset), .ksubsAbendSyndrome(syn2),
    .finished(finished2), .final_syndrome(fsyn2), .cycle_count(ccount2),
    .timed_out(tout2), .heartbeat_seen(hb2), .finish_req(freq2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    syn   = 8'h00;
    syn2  = 8'h00;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Count edges from the current point until finish_req rises, bounded.
  task automatic measure_drain(output int n);
    n = 0;
    while (freq !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
  endtask

  int gap;

  initial begin
    reset = 1'b1;
    syn   = 8'h00;
    syn2  = 8'h00;
    @(negedge clk);

    // Reset state
    do_reset();
    check("rst_finished",  32'(finished), 32'd0);
    check("rst_fsyn",      32'(fsyn),     32'd0);
    check("rst_count",     ccount,        32'd0);
    check("rst_timed_out", 32'(tout),     32'd0);
    check("rst_heartbeat", 32'(hb),       32'd0);
    check("rst_finish_req",32'(freq),     32'd0);
    check("rst2_count",    32'(ccount2),  32'd0);

    // Heartbeat for 10 clocks, then terminal 8'h01
    syn = 8'h80;
    repeat (10) tick();
    check("t1_pre_finished", 32'(finished), 32'd0);
    check("t1_pre_count",    ccount,        32'd10);
    check("t1_pre_hb",       32'(hb),       32'd1);
    syn = 8'h01;
    tick();
    check("t1_finished",   32'(finished), 32'd1);
    check("t1_fsyn",       32'(fsyn),     32'h01);
    check("t1_count",      ccount,        32'd11);
    check("t1_timed_out",  32'(tout),     32'd0);
    check("t1_finish_req", 32'(freq),     32'd0);

    // Input changes during drain are ignored
    syn = 8'h42;
    measure_drain(gap);
    check("t2_drain_gap",  32'(gap),      32'd26);
    check("t2_fsyn",       32'(fsyn),     32'h01);
    check("t2_count",      ccount,        32'd11);
    syn = 8'h80;
    repeat (5) tick();
    check("t2_freq_sticky", 32'(freq),     32'd1);
    check("t2_fin_sticky",  32'(finished), 32'd1);
    check("t2_fsyn_done",   32'(fsyn),     32'h01);

    // Reset asserted for one clock mid-drain
    do_reset();
    syn = 8'h80;
    repeat (3) tick();
    syn = 8'h09;
    tick();
    check("t5_cap_fsyn", 32'(fsyn), 32'h09);
    syn = 8'h00;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_rst_finished",   32'(finished), 32'd0);
    check("t5_rst_fsyn",       32'(fsyn),     32'd0);
    check("t5_rst_count",      ccount,        32'd0);
    check("t5_rst_hb",         32'(hb),       32'd0);
    check("t5_rst_finish_req", 32'(freq),     32'd0);
    check("t5_rst_timed_out",  32'(tout),     32'd0);
    repeat (3) tick();
    check("t5_run_count",    ccount,        32'd3);
    check("t5_run_finished", 32'(finished), 32'd0);
    syn = 8'h07;
    tick();
    check("t5_finished", 32'(finished), 32'd1);
    check("t5_fsyn",     32'(fsyn),     32'h07);
    check("t5_count",    ccount,        32'd4);
    syn = 8'h00;
    measure_drain(gap);
    check("t5_drain_gap", 32'(gap), 32'd26);

`ifdef KIWI_ABEND_WATCHDOG_EN
    // Watchdog expiry with heartbeat held
    do_reset();
    syn = 8'h80;
    repeat (19) tick();
    check("t3_pre_finished", 32'(finished), 32'd0);
    check("t3_pre_count",    ccount,        32'd19);
    tick();
    check("t3_finished",  32'(finished), 32'd1);
    check("t3_timed_out", 32'(tout),     32'd1);
    check("t3_fsyn",      32'(fsyn),     32'hFD);
    check("t3_count",     ccount,        32'd20);
    repeat (3) tick();
    check("t3_count_frozen", ccount, 32'd20);
    measure_drain(gap);
    check("t3_drain_gap", 32'(gap), 32'd23);

    // Terminal input coincident with expiry wins
    do_reset();
    syn = 8'h80;
    repeat (19) tick();
    syn = 8'h05;
    tick();
    check("t4_finished",  32'(finished), 32'd1);
    check("t4_fsyn",      32'(fsyn),     32'h05);
    check("t4_timed_out", 32'(tout),     32'd0);
    check("t4_count",     ccount,        32'd20);

    // Small instance: watchdog at 10 fires before saturation
    do_reset();
    syn2 = 8'h80;
    repeat (20) tick();
    check("s_wd_count",     32'(ccount2),   32'd10);
    check("s_wd_timed_out", 32'(tout2),     32'd1);
    check("s_wd_fsyn",      32'(fsyn2),     32'hFD);
`else
    // No watchdog: heartbeat for 100 clocks never finishes
    do_reset();
    syn = 8'h80;
    repeat (100) tick();
    check("t6_finished",  32'(finished), 32'd0);
    check("t6_timed_out", 32'(tout),     32'd0);
    check("t6_count",     ccount,        32'd100);
    check("t6_finish_req",32'(freq),     32'd0);

    // Small instance: 4-bit counter saturates at 15
    do_reset();
    syn2 = 8'h80;
    repeat (20) tick();
    check("s_sat_count",    32'(ccount2),   32'd15);
    check("s_sat_finished", 32'(finished2), 32'd0);
    check("s_sat_hb",       32'(hb2),       32'd1);
`endif

    // Zero drain: finish_req one edge after finished
    do_reset();
    repeat (2) tick();
    syn2 = 8'h33;
    tick();
    check("d0_finished",   32'(finished2), 32'd1);
    check("d0_fsyn",       32'(fsyn2),     32'h33);
    check("d0_count",      32'(ccount2),   32'd3);
    check("d0_freq_early", 32'(freq2),     32'd0);
    check("d0_hb",         32'(hb2),       32'd0);
    syn2 = 8'h00;
    tick();
    check("d0_freq", 32'(freq2), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
